// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter:
//   - geometry defaults (address width, block width, block offset bits)
//   - the fixed memory latency, which is the cache miss time
//   - FSM state encodings and requester (owner) codes
//   - a small helper that returns the other requester
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int BLOCK_SIZE      = 1024;
    localparam int BLOCK_OFF_BITS  = 7;
    localparam int CACHE_MISS_TIME = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ACK   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   reqs[0]    icache request
//   reqs[1]    dcache request
//   last_grant owner served most recently
//   grant      one-hot grant (bit order as reqs), all zero when nobody asks
// With both requesting, the side that was not served last wins.
// ----------------------------------------------------------------------------
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] reqs,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (reqs == 2'b11) begin
            grant = (other_owner(last_grant) == OWN_D) ? 2'b10 : 2'b01;
        end else begin
            grant = reqs;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single block-wide memory port between icache refills and dcache
// refills/writebacks, times each transfer with a fixed-latency counter, and
// forwards the halt flush once no cache traffic is pending.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_req/i_addr                icache refill request (level, held until ack)
//   i_ack/i_rdata               one-cycle ack, refill block
//   d_req/d_we/d_addr/d_wdata   dcache request (refill or writeback)
//   d_ack/d_rdata               one-cycle ack, refill block
//   flush_req/flush_done        halt flush request, sticky completion
//   mem_addr/mem_re/mem_we      block-aligned memory command (registered)
//   mem_wdata/mem_rdata         write block out, read block in
//   mem_flush                   sticky memory flush
// All outputs come straight from flops, so no request input reaches mem_*
// combinationally.
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = WORD_SIZE,
    parameter int BLK_W   = BLOCK_SIZE,
    parameter int OFF_W   = BLOCK_OFF_BITS,
    parameter int MEM_LAT = CACHE_MISS_TIME
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [BLK_W-1:0]  i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic              d_ack,
    output logic [BLK_W-1:0]  d_rdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    output logic              mem_flush
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    state_t             state_reg,   state_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    owner_t             last_reg,    last_next;
    owner_t             owner_reg,   owner_next;
    logic               we_reg,      we_next;
    logic [ADDR_W-1:0]  addr_reg,    addr_next;
    logic [BLK_W-1:0]   wdata_reg,   wdata_next;
    logic [BLK_W-1:0]   i_rdata_reg, i_rdata_next;
    logic [BLK_W-1:0]   d_rdata_reg, d_rdata_next;
    logic               i_ack_reg,   i_ack_next;
    logic               d_ack_reg,   d_ack_next;
    logic               re_reg,      re_next;
    logic               wr_reg,      wr_next;
    logic               flush_reg,   flush_next;

    logic [1:0]         grant;
    logic               grant_we;

    rr_pick2 u_pick (
        .reqs       ({d_req, i_req}),
        .last_grant (last_reg),
        .grant      (grant)
    );

    // Direction of the transfer about to be granted; icache only ever reads.
    assign grant_we = grant[1] & d_we;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_next    = last_reg;
        owner_next   = owner_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        i_rdata_next = i_rdata_reg;
        d_rdata_next = d_rdata_reg;
        i_ack_next   = 1'b0;
        d_ack_next   = 1'b0;
        re_next      = 1'b0;
        wr_next      = 1'b0;
        flush_next   = flush_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_next = grant[1] ? OWN_D : OWN_I;
                    addr_next  = (grant[1] ? d_addr : i_addr) & ~OFF_MASK;
                    we_next    = grant_we;
                    wdata_next = grant[1] ? d_wdata : '0;
                    cnt_next   = CNT_W'(MEM_LAT - 1);
                    // Strobes are flops, so they must rise together with BUSY.
                    re_next    = ~grant_we;
                    wr_next    = grant_we;
                    state_next = ST_BUSY;
                end else if (flush_req) begin
                    // Flush only goes out once both caches are quiet.
                    flush_next = 1'b1;
                    state_next = ST_FLUSH;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0) begin
                    if (!we_reg) begin
                        if (owner_reg == OWN_D) d_rdata_next = mem_rdata;
                        else                    i_rdata_next = mem_rdata;
                    end
                    i_ack_next = (owner_reg == OWN_I);
                    d_ack_next = (owner_reg == OWN_D);
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    re_next  = ~we_reg;
                    wr_next  = we_reg;
                end
            end
            ST_ACK: begin
                last_next  = owner_reg;
                state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                // Terminal until reset; requests are deliberately ignored.
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            last_reg    <= OWN_I;
            owner_reg   <= OWN_I;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
            i_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            re_reg      <= 1'b0;
            wr_reg      <= 1'b0;
            flush_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_reg    <= last_next;
            owner_reg   <= owner_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            i_rdata_reg <= i_rdata_next;
            d_rdata_reg <= d_rdata_next;
            i_ack_reg   <= i_ack_next;
            d_ack_reg   <= d_ack_next;
            re_reg      <= re_next;
            wr_reg      <= wr_next;
            flush_reg   <= flush_next;
        end
    end

    assign i_ack      = i_ack_reg;
    assign i_rdata    = i_rdata_reg;
    assign d_ack      = d_ack_reg;
    assign d_rdata    = d_rdata_reg;
    assign mem_addr   = addr_reg;
    assign mem_re     = re_reg;
    assign mem_we     = wr_reg;
    assign mem_wdata  = wdata_reg;
    assign flush_done = flush_reg;
    assign mem_flush  = flush_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed and randomized transfers through mem_port_arbiter, checked against
// a transaction-level expectation: who gets served, how long it takes, which
// block address and data appear on the memory port, and what each cache's
// refill register must hold afterwards.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT = 4;
    localparam int AW  = 32;
    localparam int BW  = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we, flush_req;
    logic [AW-1:0] i_addr, d_addr;
    logic [BW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, flush_done, mem_re, mem_we, mem_flush;
    logic [BW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    // Reference expectations
    logic [BW-1:0] exp_i_rdata, exp_d_rdata;
    bit            model_last_d;   // 1 when dcache was served most recently

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .BLK_W(BW), .OFF_W(7), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_flush(mem_flush)
    );

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] r;
        for (int k = 0; k < BW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] blk_align(input logic [AW-1:0] a);
        return (a / 128) * 128;
    endfunction

    // Advance until an ack appears (bounded), recording strobe activity.
    task automatic run_until_ack(output logic got_i, output logic got_d, output int ncyc,
                                 output int nre, output int nwe,
                                 output logic [AW-1:0] saddr, output logic [BW-1:0] swdata);
        got_i = 1'b0; got_d = 1'b0; ncyc = 0; nre = 0; nwe = 0; saddr = '0; swdata = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            ncyc = c;
            if (mem_re) nre++;
            if (mem_we) nwe++;
            if (mem_re || mem_we) begin
                saddr  = mem_addr;
                swdata = mem_wdata;
            end
            if (i_ack || d_ack) begin
                got_i = i_ack;
                got_d = d_ack;
                break;
            end
        end
    endtask

    // One isolated transfer: request starts in the current cycle (cycle 1).
    task automatic do_single(input string tag, input bit is_d, input bit we,
                             input logic [AW-1:0] addr, input logic [BW-1:0] wdata);
        logic          gi, gd;
        int            nc, nr, nw;
        logic [AW-1:0] sa;
        logic [BW-1:0] sw, blk;
        blk = rand_blk();
        mem_rdata = blk;
        if (is_d) begin
            d_addr = addr; d_we = we; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        run_until_ack(gi, gd, nc, nr, nw, sa, sw);
        i_req = 1'b0; d_req = 1'b0;
        mem_rdata = rand_blk();
        $display("xfer %s: %s we=%0d addr=%h ack_cycle=%0d re_cycles=%0d we_cycles=%0d",
                 tag, is_d ? "D" : "I", we, addr, nc + 1, nr, nw);
        chk({tag, "_ack_owner"}, {gi, gd}, is_d ? 2'b01 : 2'b10);
        chk({tag, "_ack_cycle"}, nc + 1, LAT + 2);
        chk({tag, "_re_cycles"}, nr, we ? 0 : LAT);
        chk({tag, "_we_cycles"}, nw, we ? LAT : 0);
        chk({tag, "_mem_addr"}, sa, blk_align(addr));
        if (we) chk({tag, "_mem_wdata"}, sw, wdata);
        if (!we) begin
            if (is_d) exp_d_rdata = blk;
            else      exp_i_rdata = blk;
        end
        model_last_d = is_d;
        chk({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
        chk({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
        tick();
        chk({tag, "_ack_pulse"}, {i_ack, d_ack}, 2'b00);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; flush_req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        exp_i_rdata = '0; exp_d_rdata = '0; model_last_d = 1'b0;
    endtask

    initial begin
        logic          gi, gd, any_ack, any_re;
        int            nc, nr, nw;
        logic [AW-1:0] sa;
        logic [BW-1:0] sw, blk, pat_a;
        bit            want_d;

        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        exp_i_rdata = '0; exp_d_rdata = '0; model_last_d = 1'b0;

        // Reset held three cycles with an icache request already pending.
        i_req = 1'b1; i_addr = 32'h0000_04A4;
        any_re = 1'b0;
        repeat (3) begin
            tick();
            any_re |= mem_re;
        end
        chk("rst_no_re", any_re, 1'b0);
        chk("rst_ctl", {i_ack, d_ack, flush_done, mem_re, mem_we, mem_flush}, 6'b0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", {i_rdata, d_rdata, mem_wdata}, 0);
        rst_n = 1'b1;
        $display("reset: released with i_req pending");

        do_single("irefill", 1'b0, 1'b0, 32'h0000_04A4, '0);

        // Writeback must leave the dcache refill register untouched.
        pat_a = rand_blk();
        do_single("dwb", 1'b1, 1'b1, 32'h0000_1C00, pat_a);
        do_single("drefill", 1'b1, 1'b0, $urandom, '0);
        do_single("dwb2", 1'b1, 1'b1, $urandom, rand_blk());

        // Contention straight after reset: icache counts as last served.
        reset_dut();
        blk = rand_blk();
        mem_rdata = blk;
        d_we = 1'b0; d_addr = $urandom; i_addr = $urandom;
        i_req = 1'b1; d_req = 1'b1;
        run_until_ack(gi, gd, nc, nr, nw, sa, sw);
        d_req = 1'b0;
        exp_d_rdata = blk;
        $display("contend first: i_ack=%0d d_ack=%0d cycle=%0d", gi, gd, nc + 1);
        chk("contend_first_d", {gi, gd}, 2'b01);
        chk("contend_d_rdata", d_rdata, exp_d_rdata);
        blk = rand_blk();
        mem_rdata = blk;
        run_until_ack(gi, gd, nc, nr, nw, sa, sw);
        i_req = 1'b0;
        exp_i_rdata = blk;
        $display("contend second: i_ack=%0d d_ack=%0d edges=%0d", gi, gd, nc);
        chk("contend_second_i", {gi, gd}, 2'b10);
        chk("contend_i_latency", nc, LAT + 2);
        chk("contend_i_rdata", i_rdata, exp_i_rdata);
        model_last_d = 1'b0;

        // Both requests held permanently: service must alternate.
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int t = 0; t < 6; t++) begin
            blk = rand_blk();
            mem_rdata = blk;
            want_d = !model_last_d;
            run_until_ack(gi, gd, nc, nr, nw, sa, sw);
            if (t == 5) begin i_req = 1'b0; d_req = 1'b0; end
            if (want_d) exp_d_rdata = blk; else exp_i_rdata = blk;
            model_last_d = want_d;
            $display("alternate %0d: i_ack=%0d d_ack=%0d want=%s", t, gi, gd, want_d ? "D" : "I");
            chk("alt_owner", {gi, gd}, want_d ? 2'b01 : 2'b10);
            chk("alt_rdata", want_d ? d_rdata : i_rdata, blk);
        end
        tick();

        // Randomized isolated transfers.
        for (int t = 0; t < 10; t++) begin
            bit rd, rw;
            rd = 1'($urandom_range(0, 1));
            rw = rd ? 1'($urandom_range(0, 1)) : 1'b0;
            do_single("rand", rd, rw, $urandom, rand_blk());
        end

        // Flush raised mid-transfer: transfer completes, then flush.
        blk = rand_blk();
        mem_rdata = blk;
        d_we = 1'b0; d_addr = $urandom; d_req = 1'b1;
        tick(); tick();
        flush_req = 1'b1;
        run_until_ack(gi, gd, nc, nr, nw, sa, sw);
        d_req = 1'b0;
        exp_d_rdata = blk;
        $display("flush: dcache transfer acked i=%0d d=%0d", gi, gd);
        chk("flush_d_ack", {gi, gd}, 2'b01);
        chk("flush_d_rdata", d_rdata, exp_d_rdata);
        tick();
        chk("flush_idle_low", mem_flush, 1'b0);
        tick();
        chk("flush_rise", {mem_flush, flush_done}, 2'b11);
        i_req = 1'b1; i_addr = $urandom;
        any_ack = 1'b0; any_re = 1'b0;
        repeat (12) begin
            tick();
            any_ack |= i_ack | d_ack;
            any_re  |= mem_re | mem_we;
        end
        i_req = 1'b0; flush_req = 1'b0;
        $display("flush: later i_req ack=%0d strobe=%0d mem_flush=%0d", any_ack, any_re, mem_flush);
        chk("flush_no_ack", any_ack, 1'b0);
        chk("flush_no_strobe", any_re, 1'b0);
        chk("flush_sticky", {mem_flush, flush_done}, 2'b11);

        // Reset in the middle of a transfer, counter at 2.
        reset_dut();
        d_we = 1'b0; d_addr = $urandom; d_req = 1'b1;
        mem_rdata = rand_blk();
        tick(); tick();
        chk("midrst_busy", mem_re, 1'b1);
        rst_n = 1'b0; d_req = 1'b0;
        tick();
        chk("midrst_strobes", {mem_re, mem_we, d_ack}, 3'b000);
        rst_n = 1'b1;
        any_ack = 1'b0;
        repeat (6) begin
            tick();
            any_ack |= i_ack | d_ack;
        end
        $display("midreset: ack after abort=%0d", any_ack);
        chk("midrst_no_ack", any_ack, 1'b0);
        chk("midrst_rdata", d_rdata, exp_d_rdata);
        do_single("after_rst", 1'b0, 1'b0, $urandom, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
